distribute_out_buffer_2ch: RTL and testbench

- Registered output stage placed directly downstream of a combinational 1x2 distribute switch.
- Takes the switch's per-branch valid bits and its {high, low} data bus, and buffers each branch in an independent FIFO.
- Each branch is presented to its downstream consumer with a valid/ready handshake.
- Backpressure to the switch is a single o_ready. Acceptance is atomic, so a Duplicate (both branches valid) is never split across cycles.

---
 rtl/distribute_out_buffer_2ch_if.sv | 23 ++
 rtl/distribute_out_buffer_2ch.sv | 73 +++++++
 tb/tb_distribute_out_buffer_2ch.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/distribute_out_buffer_2ch_if.sv
// Handshake bundle between a 1x2 distribute switch, its output buffer stage,
// and the two downstream branch consumers.
interface distribute_out_buffer_2ch_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      i_en;
    logic [1:0]                i_valid;
    logic [2*DATA_WIDTH-1:0]   i_data_bus;
    logic                      o_ready;
    logic [1:0]                o_valid;
    logic [2*DATA_WIDTH-1:0]   o_data_bus;
    logic [1:0]                i_ready;

    modport master (
        output i_en, i_valid, i_data_bus, i_ready,
        input  o_ready, o_valid, o_data_bus
    );

    modport slave (
        input  i_en, i_valid, i_data_bus, i_ready,
        output o_ready, o_valid, o_data_bus
    );
endinterface

// File: rtl/distribute_out_buffer_2ch.sv
// Two independent branch FIFOs behind a 1x2 distribute switch; acceptance is
// atomic across branches so a duplicate is never split over cycles.
module distribute_out_buffer_2ch #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    distribute_out_buffer_2ch_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] push;
    logic [1:0] pop;

    // Ready looks only at registered occupancy, never at i_valid/i_ready,
    // so no combinational path runs through the stage.
    assign bus.o_ready = ~rst & ~full[0] & ~full[1];

    for (genvar j = 0; j < 2; j++) begin : g_ch
        logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
        logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
        logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
        logic [CNT_W-1:0]      cnt_q, cnt_d;

        assign full[j]  = (cnt_q == CNT_W'(FIFO_DEPTH));
        assign empty[j] = (cnt_q == '0);
        assign push[j]  = bus.i_en & bus.o_ready & bus.i_valid[j];
        assign pop[j]   = bus.o_valid[j] & bus.i_ready[j];

        assign bus.o_valid[j] = ~empty[j];
        assign bus.o_data_bus[j*DATA_WIDTH +: DATA_WIDTH] =
            empty[j] ? '0 : mem_q[rd_ptr_q];

        // NOTE: combinational next-state uses blocking '=' with every output
        // defaulted first, so no latch can be inferred.
        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            cnt_d    = cnt_q;
            if (push[j]) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop[j])  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push[j], pop[j]})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // NOTE: storage is deliberately left unreset; a slot is only ever
        // presented after a push has written it, and empty heads read as zero.
        always_ff @(posedge clk) begin
            if (push[j]) begin
                mem_q[wr_ptr_q] <= bus.i_data_bus[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end
endmodule

// File: tb/tb_distribute_out_buffer_2ch.sv
// Self-checking bench: directed vector table, reset corner cases, and a
// randomized phase against a queue-based reference model.
module tb_distribute_out_buffer_2ch;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    typedef struct {
        logic          en;
        logic [1:0]    valid;
        logic [DW-1:0] hi;
        logic [DW-1:0] lo;
        logic [1:0]    rdy;
        logic          exp_ready;
        logic [1:0]    exp_valid;
        logic [DW-1:0] exp_hi;
        logic [DW-1:0] exp_lo;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[$];
    logic [DW-1:0] q_lo[$];
    logic [DW-1:0] q_hi[$];

    distribute_out_buffer_2ch_if #(.DATA_WIDTH(DW)) bus ();

    distribute_out_buffer_2ch #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic en, input logic [1:0] valid,
                         input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                         input logic [1:0] rdy);
        bus.i_en       = en;
        bus.i_valid    = valid;
        bus.i_data_bus = {hi, lo};
        bus.i_ready    = rdy;
    endtask

    task automatic add_vec(input logic en, input logic [1:0] valid,
                           input logic [DW-1:0] hi, input logic [DW-1:0] lo,
                           input logic [1:0] rdy, input logic exp_ready,
                           input logic [1:0] exp_valid,
                           input logic [DW-1:0] exp_hi, input logic [DW-1:0] exp_lo);
        vec_t v;
        v.en = en; v.valid = valid; v.hi = hi; v.lo = lo; v.rdy = rdy;
        v.exp_ready = exp_ready; v.exp_valid = exp_valid;
        v.exp_hi = exp_hi; v.exp_lo = exp_lo;
        vecs.push_back(v);
    endtask

    task automatic check_outputs(input string tag, input logic exp_ready,
                                 input logic [1:0] exp_valid,
                                 input logic [DW-1:0] exp_hi, input logic [DW-1:0] exp_lo);
        check({tag, " o_ready"}, 64'(bus.o_ready), 64'(exp_ready));
        check({tag, " o_valid"}, 64'(bus.o_valid), 64'(exp_valid));
        check({tag, " hi"}, 64'(bus.o_data_bus[2*DW-1:DW]), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.o_data_bus[DW-1:0]), 64'(exp_lo));
    endtask

    initial begin
        // Reset held with a duplicate request on the inputs.
        rst = 1'b1;
        drive(1'b1, 2'b11, 32'hFFFF_0000, 32'h0000_FFFF, 2'b11);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", 1'b0, 2'b00, '0, '0);
        rst = 1'b0;
        drive(1'b1, 2'b00, '0, '0, 2'b00);
        @(posedge clk);
        @(negedge clk);
        check_outputs("post_reset", 1'b1, 2'b00, '0, '0);

        // Directed table: duplicate, low fill/stall, drain, enable, wrap.
        add_vec(1, 2'b11, 32'hA5A5_0001, 32'hA5A5_0001, 2'b11, 1, 2'b11, 32'hA5A5_0001, 32'hA5A5_0001);
        add_vec(1, 2'b00, 32'h0, 32'h0, 2'b11, 1, 2'b00, 32'h0, 32'h0);
        add_vec(1, 2'b01, 32'h0, 32'd1, 2'b00, 1, 2'b01, 32'h0, 32'd1);
        add_vec(1, 2'b01, 32'h0, 32'd2, 2'b00, 0, 2'b01, 32'h0, 32'd1);
        add_vec(1, 2'b11, 32'd3, 32'd3, 2'b00, 0, 2'b01, 32'h0, 32'd1);
        add_vec(1, 2'b10, 32'd3, 32'd3, 2'b00, 0, 2'b01, 32'h0, 32'd1);
        add_vec(1, 2'b00, 32'h0, 32'h0, 2'b01, 1, 2'b01, 32'h0, 32'd2);
        add_vec(1, 2'b00, 32'h0, 32'h0, 2'b01, 1, 2'b00, 32'h0, 32'h0);
        add_vec(0, 2'b11, 32'h77, 32'h88, 2'b00, 1, 2'b00, 32'h0, 32'h0);
        for (int k = 10; k <= 17; k++)
            add_vec(1, 2'b01, 32'hDEAD_0000 + k, 32'(k), 2'b01, 1, 2'b01, 32'h0, 32'(k));
        add_vec(1, 2'b00, 32'h0, 32'h0, 2'b01, 1, 2'b00, 32'h0, 32'h0);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].valid, vecs[i].hi, vecs[i].lo, vecs[i].rdy);
            @(posedge clk);
            @(negedge clk);
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_ready, vecs[i].exp_valid,
                          vecs[i].exp_hi, vecs[i].exp_lo);
        end

        // Mid-operation asynchronous reset with one entry per branch.
        drive(1'b1, 2'b11, 32'h55, 32'h66, 2'b00);
        @(posedge clk);
        @(negedge clk);
        check_outputs("pre_async", 1'b1, 2'b11, 32'h55, 32'h66);
        drive(1'b1, 2'b00, '0, '0, 2'b00);
        #2 rst = 1'b1;
        #1 check_outputs("async_rst", 1'b0, 2'b00, '0, '0);
        @(negedge clk);
        rst = 1'b0;
        #1 check_outputs("async_release", 1'b1, 2'b00, '0, '0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            @(negedge clk);
            check_outputs("after_rst", 1'b1, 2'b00, '0, '0);
        end

        // Randomized traffic against a queue-per-branch reference model.
        q_lo.delete();
        q_hi.delete();
        for (int c = 0; c < 400; c++) begin
            logic          m_ready;
            logic          en;
            logic [1:0]    valid;
            logic [1:0]    rdy;
            logic [DW-1:0] hi;
            logic [DW-1:0] lo;
            m_ready = (q_lo.size() < DEPTH) && (q_hi.size() < DEPTH);
            check_outputs("rand", m_ready,
                          {q_hi.size() != 0, q_lo.size() != 0},
                          (q_hi.size() != 0) ? q_hi[0] : '0,
                          (q_lo.size() != 0) ? q_lo[0] : '0);
            en    = ($urandom_range(0, 7) != 0);
            valid = 2'($urandom_range(0, 3));
            rdy   = 2'($urandom_range(0, 3));
            hi    = $urandom;
            lo    = $urandom;
            drive(en, valid, hi, lo, rdy);
            if (rdy[0] && q_lo.size() != 0) void'(q_lo.pop_front());
            if (rdy[1] && q_hi.size() != 0) void'(q_hi.pop_front());
            if (en && m_ready && valid[0]) q_lo.push_back(lo);
            if (en && m_ready && valid[1]) q_hi.push_back(hi);
            @(posedge clk);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
